// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Drives one column low at a time, watches the synchronised rows, and reports
// a single debounced key as {4'h0, row, col} with a one-cycle event pulse.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEB_CNT  = 1000
) (
  input  logic       CK,
  input  logic       RST_N,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [7:0] KEY_CODE,
  output logic       key_event,
  output logic       KEY_DOWN
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEB_CNT  > 1) ? $clog2(DEB_CNT)  : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [1:0]    c, c_n;
  logic [CW-1:0] dc, dc_n;
  logic [CW-1:0] rc, rc_n;
  logic [3:0]    pat, pat_n;
  logic [1:0]    r, r_n;
  logic [7:0]    code, code_n;
  logic          evt, evt_n;
  logic          down, down_n;
  logic [3:0]    s1, rs;

  // Lowest-index low row wins when several rows in a column are pressed.
  function automatic logic [1:0] low_row(input logic [3:0] v);
    casez (v)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous row lines (idle = all high).
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      s1 <= 4'hF;
      rs <= 4'hF;
    end else begin
      s1 <= ROW;
      rs <= s1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state <= SCAN;
      div   <= '0;
      c     <= 2'd0;
      dc    <= '0;
      rc    <= '0;
      pat   <= 4'hF;
      r     <= 2'd0;
      code  <= 8'h00;
      evt   <= 1'b0;
      down  <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      c     <= c_n;
      dc    <= dc_n;
      rc    <= rc_n;
      pat   <= pat_n;
      r     <= r_n;
      code  <= code_n;
      evt   <= evt_n;
      down  <= down_n;
    end
  end

  // Next-state logic: scan columns, debounce the press, then debounce the release.
  always_comb begin
    state_n = state;
    div_n   = div;
    c_n     = c;
    dc_n    = dc;
    rc_n    = rc;
    pat_n   = pat;
    r_n     = r;
    code_n  = code;
    evt_n   = 1'b0;
    down_n  = down;
    case (state)
      SCAN: begin
        // Rows are only trusted at the end of the column's settling window.
        if (div == DIV_MAX) begin
          div_n = '0;
          if (rs == 4'hF) begin
            c_n = c + 2'd1;
          end else begin
            pat_n   = rs;
            r_n     = low_row(rs);
            dc_n    = '0;
            state_n = DEBOUNCE;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != pat) begin
          // Pattern moved: rescan the same column from a fresh window.
          state_n = SCAN;
          div_n   = '0;
          dc_n    = '0;
        end else if (dc == DEB_MAX) begin
          code_n  = {4'h0, r, c};
          evt_n   = 1'b1;
          down_n  = 1'b1;
          rc_n    = '0;
          dc_n    = '0;
          state_n = HOLD;
        end else begin
          dc_n = dc + 1'b1;
        end
      end
      HOLD: begin
        // Column stays put so keys in other columns are invisible until release.
        if (rs != 4'hF) begin
          rc_n = '0;
        end else if (rc == DEB_MAX) begin
          down_n  = 1'b0;
          c_n     = c + 2'd1;
          div_n   = '0;
          rc_n    = '0;
          state_n = SCAN;
        end else begin
          rc_n = rc + 1'b1;
        end
      end
      default: begin
        state_n = SCAN;
        div_n   = '0;
        dc_n    = '0;
        rc_n    = '0;
      end
    endcase
  end

  assign COL       = ~(4'b0001 << c);
  assign KEY_CODE  = code;
  assign key_event = evt;
  assign KEY_DOWN  = down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives ROW from COL and a
// set of pressed keys; expected codes go into a queue, a monitor checks events.
module tb_keypad_scanner;

  logic       CK;
  logic       RST_N;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [7:0] KEY_CODE;
  logic       key_event;
  logic       KEY_DOWN;

  logic [15:0] keys;
  logic        row_force;
  logic [3:0]  row_val;
  logic [7:0]  exp_q[$];
  int          checks;
  int          errors;

  keypad_scanner #(.SCAN_DIV(4), .DEB_CNT(8)) dut (
    .CK(CK), .RST_N(RST_N), .ROW(ROW), .COL(COL),
    .KEY_CODE(KEY_CODE), .key_event(key_event), .KEY_DOWN(KEY_DOWN)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Keypad model: row r goes low when a pressed key (r,c) has its column driven low.
  always_comb begin
    ROW = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && (COL[cc] == 1'b0)) ROW[rr] = 1'b0;
    if (row_force) ROW = row_val;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every key_event pops one expected code.
  always @(negedge CK) begin
    if (key_event === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%h required=none", KEY_CODE);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("event_code", KEY_CODE, e);
        chk("event_down", {7'd0, KEY_DOWN}, 8'h01);
      end
    end
  end

  // Wait (bounded) for KEY_DOWN to fall; returns at the negedge where it is first 0.
  task automatic wait_release(input string nm, input int max);
    int n;
    n = 0;
    @(negedge CK);
    while (KEY_DOWN !== 1'b0 && n < max) begin
      @(negedge CK);
      n++;
    end
    chk(nm, {7'd0, KEY_DOWN}, 8'h00);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    keys      = 16'h0;
    row_force = 1'b1;
    row_val   = 4'b0000;
    RST_N     = 1'b0;

    // Reset with all rows low: nothing may happen.
    repeat (3) @(negedge CK);
    chk("rst_col",   {4'h0, COL}, 8'h0E);
    chk("rst_code",  KEY_CODE, 8'h00);
    chk("rst_event", {7'd0, key_event}, 8'h00);
    chk("rst_down",  {7'd0, KEY_DOWN}, 8'h00);
    row_force = 1'b0;
    RST_N     = 1'b1;

    // Clean press row2/col1.
    exp_q.push_back(8'h09);
    keys[9] = 1'b1;
    repeat (40) @(negedge CK);
    chk("clean_code", KEY_CODE, 8'h09);
    chk("clean_down", {7'd0, KEY_DOWN}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("clean_col_frozen", {4'h0, COL}, 8'h0D);
      @(negedge CK);
    end
    keys[9] = 1'b0;
    wait_release("clean_release", 30);
    chk("clean_col_after", {4'h0, COL}, 8'h0B);

    // Bounce on row0/col3, then stable.
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) keys[3] = ~keys[3];
      @(negedge CK);
    end
    chk("bounce_down", {7'd0, KEY_DOWN}, 8'h00);
    exp_q.push_back(8'h03);
    keys[3] = 1'b1;
    repeat (40) @(negedge CK);
    chk("bounce_code", KEY_CODE, 8'h03);
    chk("bounce_kdown", {7'd0, KEY_DOWN}, 8'h01);
    keys[3] = 1'b0;
    wait_release("bounce_release", 30);

    // Release debounce with a 2-cycle glitch at release cycle 5, key row3/col0.
    exp_q.push_back(8'h0C);
    keys[12] = 1'b1;
    repeat (40) @(negedge CK);
    chk("rel_down_held", {7'd0, KEY_DOWN}, 8'h01);
    @(posedge CK); #1 keys[12] = 1'b0;
    repeat (4) @(posedge CK);
    #1 keys[12] = 1'b1;
    repeat (2) @(posedge CK);
    #1 keys[12] = 1'b0;
    repeat (6) @(posedge CK);
    @(negedge CK);
    chk("rel_glitch_still_down", {7'd0, KEY_DOWN}, 8'h01);
    wait_release("rel_release", 20);
    chk("rel_col_after", {4'h0, COL}, 8'h0D);
    chk("rel_code_kept", KEY_CODE, 8'h0C);

    // Multi-key: rows 1 and 3 in column 2, then a column-0 key during hold.
    exp_q.push_back(8'h06);
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    repeat (40) @(negedge CK);
    chk("multi_code", KEY_CODE, 8'h06);
    chk("multi_down", {7'd0, KEY_DOWN}, 8'h01);
    keys[8] = 1'b1;
    repeat (30) @(negedge CK);
    chk("multi_hold_code", KEY_CODE, 8'h06);
    chk("multi_hold_col", {4'h0, COL}, 8'h0B);
    exp_q.push_back(8'h08);
    keys[6]  = 1'b0;
    keys[14] = 1'b0;
    wait_release("multi_release", 30);
    repeat (40) @(negedge CK);
    chk("multi_second_code", KEY_CODE, 8'h08);
    keys[8] = 1'b0;
    wait_release("multi_second_release", 30);

    // Reset mid-debounce: key row1/col0 captured, reset at dc=4.
    @(posedge CK); #1 RST_N = 1'b0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("rst2_code", KEY_CODE, 8'h00);
    @(posedge CK); #1;
    RST_N   = 1'b1;
    keys[4] = 1'b1;
    repeat (8) @(posedge CK);
    #1;
    RST_N = 1'b0;
    keys  = 16'h0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("mid_rst_col",  {4'h0, COL}, 8'h0E);
    chk("mid_rst_code", KEY_CODE, 8'h00);
    @(posedge CK); #1 RST_N = 1'b1;
    repeat (30) @(negedge CK);
    chk("mid_rst_code_after", KEY_CODE, 8'h00);
    chk("mid_rst_down_after", {7'd0, KEY_DOWN}, 8'h00);

    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
